// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared state encoding and defaults for the pipeline stall controller
package arm_pipe_pkg;

  localparam logic [1:0] STATE_RUN      = 2'd0;
  localparam logic [1:0] STATE_MEM_WAIT = 2'd1;
  localparam logic [1:0] STATE_ERROR    = 2'd2;

  localparam int SRAM_TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_RUN      = STATE_RUN,
    ST_MEM_WAIT = STATE_MEM_WAIT,
    ST_ERROR    = STATE_ERROR
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear priority
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - merges hazard, branch and SRAM stalls into per-stage freeze/flush lines
module pipeline_stall_controller
  import arm_pipe_pkg::*;
#(
  parameter int SRAM_TIMEOUT = SRAM_TIMEOUT_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  input  logic             cnt_clr,
  output logic             sram_start,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_exe,
  output logic             freeze_mem,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(SRAM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic start_c, freeze_all_c, upstream_c;
  logic fif_c, fid_c, flush_c, bubble_c;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    start_c       = 1'b0;
    freeze_all_c  = 1'b0;
    upstream_c    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_r_en || mem_w_en) begin
          start_c      = 1'b1;
          freeze_all_c = 1'b1;
          wait_cnt_d   = '0;
          state_d      = ST_MEM_WAIT;
        end else begin
          upstream_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // Ready wins over the timeout threshold on the same cycle.
        if (sram_ready) begin
          upstream_c = 1'b1;
          state_d    = ST_RUN;
        end else begin
          freeze_all_c = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = ST_ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      ST_ERROR: begin
        freeze_all_c  = 1'b1;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // A taken branch makes the ID instruction wrong-path, so its hazard is moot.
  always_comb begin
    fif_c    = freeze_all_c;
    fid_c    = freeze_all_c;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    if (upstream_c) begin
      if (branch_taken) begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
      end else if (hazard_detected) begin
        fif_c    = 1'b1;
        fid_c    = 1'b1;
        bubble_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign sram_start    = rst & start_c;
  assign freeze_if     = rst & fif_c;
  assign freeze_id     = rst & fid_c;
  assign freeze_exe    = rst & freeze_all_c;
  assign freeze_mem    = rst & freeze_all_c;
  assign flush_if_id   = rst & flush_c;
  assign bubble_id_exe = rst & bubble_c;
  assign mem_timeout   = rst & mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (freeze_if),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (flush_if_id),
    .q   (flush_cnt)
  );

endmodule
